// File: rtl/commutation_sequencer.sv
// Supervisory sequencer between the assist/torque path and the BLDC commutation block:
// run/dead/brake/fault sequencing, drive-magnitude slew limiting, stall/hall checks and hall period.
module commutation_sequencer #(
   parameter int DEAD_CYC  = 50,
   parameter int RAMP_DIV  = 256,
   parameter int STALL_CYC = 5_000_000,
   parameter int INVAL_CYC = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  hall_state,
   input  logic        brake_n,
   input  logic [11:0] drv_mag_req,
   input  logic        clr_fault,
   output logic [11:0] drv_mag,
   output logic        force_hiz,
   output logic        brake_req,
   output logic        fault,
   output logic [15:0] hall_period,
   output logic        period_vld
);

   localparam int DW = $clog2(DEAD_CYC + 1);
   localparam int RW = $clog2(RAMP_DIV + 1);
   localparam int SW = $clog2(STALL_CYC + 1);
   localparam int IW = $clog2(INVAL_CYC + 1);
   localparam logic [DW-1:0] DEAD_LAST  = DW'(DEAD_CYC - 1);
   localparam logic [RW-1:0] RAMP_LAST  = RW'(RAMP_DIV - 1);
   localparam logic [SW-1:0] STALL_LAST = SW'(STALL_CYC - 1);
   localparam logic [SW-1:0] STALL_MAX  = SW'(STALL_CYC);
   localparam logic [IW-1:0] INVAL_LAST = IW'(INVAL_CYC - 1);
   localparam logic [IW-1:0] INVAL_MAX  = IW'(INVAL_CYC);

   typedef enum logic [2:0] {S_IDLE, S_RUN, S_DEAD, S_BRAKE, S_FAULT} state_t;

   state_t        state_q, state_d;
   logic [2:0]    hall_prev_q, hall_prev_d;
   logic [DW-1:0] dead_cnt_q, dead_cnt_d;
   logic [RW-1:0] ramp_cnt_q, ramp_cnt_d;
   logic [SW-1:0] stall_cnt_q, stall_cnt_d;
   logic [IW-1:0] inval_cnt_q, inval_cnt_d;
   logic [15:0]   period_cnt_q, period_cnt_d;
   logic [11:0]   drv_mag_q, drv_mag_d;
   logic          force_hiz_q, force_hiz_d;
   logic          brake_req_q, brake_req_d;
   logic          fault_q, fault_d;
   logic [15:0]   hall_period_q, hall_period_d;
   logic          period_vld_q, period_vld_d;

   logic hall_valid, hall_edge, driving, inval_counting, stall_hit, inval_hit;

   always_comb begin
      hall_valid     = (hall_state != 3'b000) && (hall_state != 3'b111);
      hall_edge      = hall_valid && (hall_state != hall_prev_q);
      driving        = (state_q == S_RUN) || (state_q == S_DEAD);
      inval_counting = (state_q != S_BRAKE) && (state_q != S_FAULT);
      stall_hit      = driving && !hall_edge && (drv_mag_q != '0) && (stall_cnt_q >= STALL_LAST);
      inval_hit      = inval_counting && !hall_valid && (inval_cnt_q >= INVAL_LAST);
   end

   always_comb begin
      state_d    = state_q;
      dead_cnt_d = dead_cnt_q;
      if ((state_q != S_FAULT) && (stall_hit || inval_hit)) begin
         state_d = S_FAULT;
      end else if (!brake_n && (state_q inside {S_IDLE, S_RUN, S_DEAD})) begin
         state_d = S_BRAKE;
      end else begin
         case (state_q)
            S_IDLE:  if ((drv_mag_req != '0) && hall_valid) state_d = S_RUN;
            S_RUN: begin
               if (hall_edge) begin
                  state_d    = S_DEAD;
                  dead_cnt_d = DEAD_LAST;
               end else if ((drv_mag_req == '0) && (drv_mag_q == '0)) begin
                  state_d = S_IDLE;
               end
            end
            // a fresh commutation change restarts the whole dead-time window
            S_DEAD: begin
               if (hall_edge)               dead_cnt_d = DEAD_LAST;
               else if (dead_cnt_q == '0)   state_d    = S_RUN;
               else                         dead_cnt_d = dead_cnt_q - DW'(1);
            end
            S_BRAKE: if (brake_n)   state_d = S_IDLE;
            S_FAULT: if (clr_fault) state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Slew only while staying in a driving state; anything else zeroes magnitude and phase.
   always_comb begin
      drv_mag_d  = '0;
      ramp_cnt_d = '0;
      if (driving && ((state_d == S_RUN) || (state_d == S_DEAD))) begin
         drv_mag_d = drv_mag_q;
         if (drv_mag_q > drv_mag_req) begin
            drv_mag_d = drv_mag_req;
         end else if (drv_mag_q < drv_mag_req) begin
            if (ramp_cnt_q >= RAMP_LAST) drv_mag_d  = drv_mag_q + 12'd1;
            else                         ramp_cnt_d = ramp_cnt_q + RW'(1);
         end
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (!driving || hall_edge)                              stall_cnt_d = '0;
      else if ((drv_mag_q != '0) && (stall_cnt_q < STALL_MAX)) stall_cnt_d = stall_cnt_q + SW'(1);

      // held (not cleared) in FAULT so a clear during a persisting bad code re-faults
      inval_cnt_d = inval_cnt_q;
      if (hall_valid)                                         inval_cnt_d = '0;
      else if (inval_counting && (inval_cnt_q < INVAL_MAX))   inval_cnt_d = inval_cnt_q + IW'(1);

      hall_prev_d   = hall_valid ? hall_state : hall_prev_q;
      period_vld_d  = hall_edge;
      hall_period_d = hall_edge ? period_cnt_q : hall_period_q;
      if (hall_edge)                    period_cnt_d = 16'd1;
      else if (period_cnt_q != 16'hFFFF) period_cnt_d = period_cnt_q + 16'd1;
      else                              period_cnt_d = period_cnt_q;

      force_hiz_d = state_d inside {S_IDLE, S_DEAD, S_FAULT};
      brake_req_d = (state_d == S_BRAKE);
      fault_d     = (state_d == S_FAULT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         hall_prev_q   <= hall_state;
         dead_cnt_q    <= '0;
         ramp_cnt_q    <= '0;
         stall_cnt_q   <= '0;
         inval_cnt_q   <= '0;
         period_cnt_q  <= 16'hFFFF;
         drv_mag_q     <= '0;
         force_hiz_q   <= 1'b1;
         brake_req_q   <= 1'b0;
         fault_q       <= 1'b0;
         hall_period_q <= 16'hFFFF;
         period_vld_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         hall_prev_q   <= hall_prev_d;
         dead_cnt_q    <= dead_cnt_d;
         ramp_cnt_q    <= ramp_cnt_d;
         stall_cnt_q   <= stall_cnt_d;
         inval_cnt_q   <= inval_cnt_d;
         period_cnt_q  <= period_cnt_d;
         drv_mag_q     <= drv_mag_d;
         force_hiz_q   <= force_hiz_d;
         brake_req_q   <= brake_req_d;
         fault_q       <= fault_d;
         hall_period_q <= hall_period_d;
         period_vld_q  <= period_vld_d;
      end
   end

   assign drv_mag     = drv_mag_q;
   assign force_hiz   = force_hiz_q;
   assign brake_req   = brake_req_q;
   assign fault       = fault_q;
   assign hall_period = hall_period_q;
   assign period_vld  = period_vld_q;

endmodule

// File: tb/tb_commutation_sequencer.sv
// Bench for commutation_sequencer: vector table, directed corner sequences and random
// stimulus, all compared cycle by cycle against a time-stamp based behavioural model.
module tb_commutation_sequencer;

   localparam int DEAD_CYC  = 4;
   localparam int RAMP_DIV  = 2;
   localparam int STALL_CYC = 100;
   localparam int INVAL_CYC = 8;

   localparam int MD_IDLE = 0, MD_RUN = 1, MD_DEAD = 2, MD_BRAKE = 3, MD_FAULT = 4;

   logic        clk;
   logic        rst;
   logic [2:0]  hall_state;
   logic        brake_n;
   logic [11:0] drv_mag_req;
   logic        clr_fault;
   logic [11:0] drv_mag;
   logic        force_hiz;
   logic        brake_req;
   logic        fault;
   logic [15:0] hall_period;
   logic        period_vld;

   commutation_sequencer #(
      .DEAD_CYC(DEAD_CYC), .RAMP_DIV(RAMP_DIV), .STALL_CYC(STALL_CYC), .INVAL_CYC(INVAL_CYC)
   ) dut (
      .clk(clk), .rst(rst), .hall_state(hall_state), .brake_n(brake_n),
      .drv_mag_req(drv_mag_req), .clr_fault(clr_fault), .drv_mag(drv_mag),
      .force_hiz(force_hiz), .brake_req(brake_req), .fault(fault),
      .hall_period(hall_period), .period_vld(period_vld)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // model: timestamps instead of down-counters, run lengths instead of saturating counters
   int m_mode, m_mag, m_hiz, m_brk, m_flt, m_period, m_vld, m_prev;
   int t_now = 0, last_edge = -1, dead_end = 0, inval_run = 0, stall_run = 0, ramp_age = 0;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h cycle=%0d", nm, act, req, t_now);
      end
   endtask

   task automatic model_step();
      bit valid, edg, driving, stall_hit, inval_hit, counting;
      int nxt, req;
      req   = int'(drv_mag_req);
      valid = (hall_state != 3'b000) && (hall_state != 3'b111);
      edg   = valid && (int'(hall_state) != m_prev);
      if (rst) begin
         m_mode = MD_IDLE; m_mag = 0; m_hiz = 1; m_brk = 0; m_flt = 0;
         m_period = 65535; m_vld = 0; m_prev = int'(hall_state);
         last_edge = -1; inval_run = 0; stall_run = 0; ramp_age = 0;
      end else begin
         driving   = (m_mode == MD_RUN) || (m_mode == MD_DEAD);
         counting  = (m_mode != MD_BRAKE) && (m_mode != MD_FAULT);
         stall_hit = driving && !edg && (m_mag != 0) && (stall_run + 1 >= STALL_CYC);
         inval_hit = counting && !valid && (inval_run + 1 >= INVAL_CYC);
         nxt = m_mode;
         if ((m_mode != MD_FAULT) && (stall_hit || inval_hit)) nxt = MD_FAULT;
         else if (!brake_n && (m_mode <= MD_DEAD)) nxt = MD_BRAKE;
         else begin
            case (m_mode)
               MD_IDLE:  if (req != 0 && valid) nxt = MD_RUN;
               MD_RUN: begin
                  if (edg) begin nxt = MD_DEAD; dead_end = t_now + DEAD_CYC; end
                  else if (req == 0 && m_mag == 0) nxt = MD_IDLE;
               end
               MD_DEAD: begin
                  if (edg) dead_end = t_now + DEAD_CYC;
                  else if (t_now >= dead_end) nxt = MD_RUN;
               end
               MD_BRAKE: if (brake_n) nxt = MD_IDLE;
               default:  if (clr_fault) nxt = MD_IDLE;
            endcase
         end
         if (!driving || edg) stall_run = 0;
         else if (m_mag != 0) stall_run++;
         if (valid) inval_run = 0;
         else if (counting) inval_run++;
         if (driving && (nxt == MD_RUN || nxt == MD_DEAD)) begin
            if (m_mag > req) begin m_mag = req; ramp_age = 0; end
            else if (m_mag < req) begin
               ramp_age++;
               if (ramp_age == RAMP_DIV) begin m_mag++; ramp_age = 0; end
            end else ramp_age = 0;
         end else begin
            m_mag = 0; ramp_age = 0;
         end
         m_vld = edg ? 1 : 0;
         if (edg) begin
            m_period  = (last_edge < 0 || t_now - last_edge > 65535) ? 65535 : t_now - last_edge;
            last_edge = t_now;
         end
         if (valid) m_prev = int'(hall_state);
         m_mode = nxt;
         m_hiz  = (nxt == MD_IDLE || nxt == MD_DEAD || nxt == MD_FAULT) ? 1 : 0;
         m_brk  = (nxt == MD_BRAKE) ? 1 : 0;
         m_flt  = (nxt == MD_FAULT) ? 1 : 0;
      end
      t_now++;
   endtask

   task automatic cyc(input logic [2:0] h, input logic b, input logic [11:0] r,
                      input logic c, input logic rs);
      hall_state = h; brake_n = b; drv_mag_req = r; clr_fault = c; rst = rs;
      model_step();
      @(posedge clk);
      #1;
      chk("drv_mag",     {4'b0, drv_mag},     16'(m_mag));
      chk("force_hiz",   {15'b0, force_hiz},  16'(m_hiz));
      chk("brake_req",   {15'b0, brake_req},  16'(m_brk));
      chk("fault",       {15'b0, fault},      16'(m_flt));
      chk("hall_period", hall_period,         16'(m_period));
      chk("period_vld",  {15'b0, period_vld}, 16'(m_vld));
   endtask

   typedef struct {
      logic [2:0]  h;
      logic        b;
      logic [11:0] r;
      logic        c;
      logic        e_hiz;
      logic        e_brk;
      logic        e_flt;
      int          e_mag;
   } vec_t;

   vec_t       tbl [20];
   logic [2:0] seq_codes [6];
   logic [2:0] hcur;
   logic [11:0] rq;
   logic       bn, cf, rs;
   int         hold, kind, pulses;

   initial begin
      //          hall  brk_n req     clr    hiz   brk   flt   mag
      tbl[0]  = '{3'd5, 1'b1, 12'd0,  1'b0, 1'b1, 1'b0, 1'b0, 0};
      tbl[1]  = '{3'd5, 1'b1, 12'd10, 1'b0, 1'b0, 1'b0, 1'b0, 0};
      tbl[2]  = '{3'd5, 1'b1, 12'd10, 1'b0, 1'b0, 1'b0, 1'b0, 0};
      tbl[3]  = '{3'd5, 1'b1, 12'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1};
      tbl[4]  = '{3'd4, 1'b1, 12'd10, 1'b0, 1'b1, 1'b0, 1'b0, 1};
      tbl[5]  = '{3'd4, 1'b1, 12'd10, 1'b0, 1'b1, 1'b0, 1'b0, 2};
      tbl[6]  = '{3'd6, 1'b1, 12'd10, 1'b0, 1'b1, 1'b0, 1'b0, 2};
      tbl[7]  = '{3'd6, 1'b1, 12'd10, 1'b0, 1'b1, 1'b0, 1'b0, 3};
      tbl[8]  = '{3'd6, 1'b1, 12'd10, 1'b0, 1'b1, 1'b0, 1'b0, 3};
      tbl[9]  = '{3'd6, 1'b1, 12'd10, 1'b0, 1'b1, 1'b0, 1'b0, 4};
      tbl[10] = '{3'd6, 1'b1, 12'd10, 1'b0, 1'b0, 1'b0, 1'b0, 4};
      tbl[11] = '{3'd6, 1'b1, 12'd3,  1'b0, 1'b0, 1'b0, 1'b0, 3};
      tbl[12] = '{3'd6, 1'b0, 12'd3,  1'b0, 1'b0, 1'b1, 1'b0, 0};
      tbl[13] = '{3'd6, 1'b0, 12'd3,  1'b0, 1'b0, 1'b1, 1'b0, 0};
      tbl[14] = '{3'd6, 1'b1, 12'd3,  1'b0, 1'b1, 1'b0, 1'b0, 0};
      tbl[15] = '{3'd6, 1'b1, 12'd3,  1'b0, 1'b0, 1'b0, 1'b0, 0};
      tbl[16] = '{3'd2, 1'b1, 12'd3,  1'b0, 1'b1, 1'b0, 1'b0, 0};
      tbl[17] = '{3'd2, 1'b0, 12'd3,  1'b0, 1'b0, 1'b1, 1'b0, 0};
      tbl[18] = '{3'd2, 1'b1, 12'd3,  1'b0, 1'b1, 1'b0, 1'b0, 0};
      tbl[19] = '{3'd2, 1'b1, 12'd0,  1'b0, 1'b1, 1'b0, 1'b0, 0};
      seq_codes = '{3'd3, 3'd1, 3'd5, 3'd4, 3'd6, 3'd2};

      cyc(3'd5, 1'b1, 12'd0, 1'b0, 1'b1);
      $display("reset: hiz=%0b mag=%0d period=%0h", force_hiz, drv_mag, hall_period);
      chk("rst_hiz", {15'b0, force_hiz}, 16'd1);
      chk("rst_mag", {4'b0, drv_mag}, 16'd0);
      chk("rst_period", hall_period, 16'hFFFF);
      chk("rst_fault", {15'b0, fault}, 16'd0);

      for (int i = 0; i < 20; i++) begin
         cyc(tbl[i].h, tbl[i].b, tbl[i].r, tbl[i].c, 1'b0);
         $display("vec %0d hall=%0d brake_n=%0b req=%0d -> hiz=%0b brk=%0b fault=%0b mag=%0d",
                  i, tbl[i].h, tbl[i].b, tbl[i].r, force_hiz, brake_req, fault, drv_mag);
         chk("tbl_hiz", {15'b0, force_hiz}, {15'b0, tbl[i].e_hiz});
         chk("tbl_brk", {15'b0, brake_req}, {15'b0, tbl[i].e_brk});
         chk("tbl_flt", {15'b0, fault}, {15'b0, tbl[i].e_flt});
         chk("tbl_mag", {4'b0, drv_mag}, 16'(tbl[i].e_mag));
      end

      // ramp to 10, hold, then drop request to 3
      for (int i = 0; i < 25; i++) cyc(3'd2, 1'b1, 12'd10, 1'b0, 1'b0);
      chk("ramp_reach", {4'b0, drv_mag}, 16'd10);
      cyc(3'd2, 1'b1, 12'd10, 1'b0, 1'b0);
      chk("ramp_hold", {4'b0, drv_mag}, 16'd10);
      cyc(3'd2, 1'b1, 12'd3, 1'b0, 1'b0);
      chk("ramp_drop", {4'b0, drv_mag}, 16'd3);
      $display("ramp: final mag=%0d", drv_mag);

      // hall changes every 37 clocks
      pulses = 0;
      for (int e = 0; e < 6; e++) begin
         for (int i = 0; i < 37; i++) begin
            cyc(seq_codes[e], 1'b1, 12'd3, 1'b0, 1'b0);
            if (period_vld === 1'b1) begin
               pulses++;
               if (e > 0) chk("period_37", hall_period, 16'd37);
            end
         end
      end
      chk("period_pulses", 16'(pulses), 16'd6);
      $display("period: pulses=%0d last_period=%0d", pulses, hall_period);

      // stall: hall frozen while driving
      for (int i = 0; i < 150 && fault !== 1'b1; i++) cyc(3'd2, 1'b1, 12'd3, 1'b0, 1'b0);
      chk("stall_fault", {15'b0, fault}, 16'd1);
      chk("stall_hiz", {15'b0, force_hiz}, 16'd1);
      chk("stall_mag", {4'b0, drv_mag}, 16'd0);
      cyc(3'd2, 1'b1, 12'd0, 1'b1, 1'b0);
      chk("clr_fault", {15'b0, fault}, 16'd0);
      chk("clr_hiz", {15'b0, force_hiz}, 16'd1);
      $display("stall: cleared fault=%0b", fault);

      // invalid hall code run
      for (int i = 0; i < 7; i++) cyc(3'd7, 1'b1, 12'd0, 1'b0, 1'b0);
      chk("inval_7", {15'b0, fault}, 16'd0);
      cyc(3'd7, 1'b1, 12'd0, 1'b0, 1'b0);
      chk("inval_8", {15'b0, fault}, 16'd1);
      cyc(3'd7, 1'b1, 12'd0, 1'b1, 1'b0);
      chk("inval_clr", {15'b0, fault}, 16'd0);
      cyc(3'd7, 1'b1, 12'd0, 1'b0, 1'b0);
      chk("inval_refault", {15'b0, fault}, 16'd1);
      cyc(3'd5, 1'b1, 12'd0, 1'b1, 1'b0);
      chk("inval_clr_ok", {15'b0, fault}, 16'd0);
      cyc(3'd5, 1'b1, 12'd0, 1'b0, 1'b0);
      chk("inval_stay", {15'b0, fault}, 16'd0);
      $display("inval: fault=%0b hiz=%0b", fault, force_hiz);

      // reset in the middle of a run, with the hall code changing at the same time
      for (int i = 0; i < 4; i++) cyc(3'd5, 1'b1, 12'd9, 1'b0, 1'b0);
      cyc(3'd4, 1'b1, 12'd9, 1'b0, 1'b1);
      chk("mid_rst_hiz", {15'b0, force_hiz}, 16'd1);
      chk("mid_rst_period", hall_period, 16'hFFFF);
      cyc(3'd4, 1'b1, 12'd0, 1'b0, 1'b0);
      chk("mid_rst_noedge", {15'b0, period_vld}, 16'd0);
      $display("midreset: hiz=%0b period=%0h", force_hiz, hall_period);

      // random stimulus against the model
      hcur = 3'd5; rq = 12'd0; hold = 0;
      for (int n = 0; n < 3000; n++) begin
         if (hold == 0) begin
            kind = int'($urandom_range(0, 99));
            if (kind < 75) begin
               hcur = 3'($urandom_range(1, 6));
               hold = int'($urandom_range(1, 60));
            end else if (kind < 87) begin
               hcur = ($urandom_range(0, 1) == 1) ? 3'b111 : 3'b000;
               hold = int'($urandom_range(1, 12));
            end else begin
               hold = int'($urandom_range(80, 130));
            end
         end
         hold--;
         if ($urandom_range(0, 39) == 0)
            rq = ($urandom_range(0, 3) == 0) ? 12'd0 : 12'($urandom_range(1, 40));
         bn = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
         cf = ($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0;
         rs = ($urandom_range(0, 999) == 0) ? 1'b1 : 1'b0;
         cyc(hcur, bn, rq, cf, rs);
      end
      $display("random: 3000 cycles done");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
